// File: rtl/dcache_wb_controller_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache controller.
package dcache_wb_controller_pkg;

    localparam int unsigned LINES      = 32;
    localparam int unsigned LINE_W     = 256;
    localparam int unsigned TAG_W      = 22;
    localparam int unsigned OFFSET_W   = 5;
    localparam int unsigned INDEX_W    = 5;
    localparam int unsigned WORD_SEL_W = 3;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned ENTRY_W    = TAG_W + 2;
    localparam int unsigned VALID_BIT  = 23;
    localparam int unsigned DIRTY_BIT  = 22;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WRITEBACK   = 2'd1,
        REFILL      = 2'd2,
        REFILL_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    // Replace one 32-bit word of a line.
    function automatic logic [LINE_W-1:0] merge_word(
        input logic [LINE_W-1:0]     line,
        input logic [WORD_SEL_W-1:0] sel,
        input logic [WORD_W-1:0]     word
    );
        logic [LINE_W-1:0] merged;
        merged = line;
        merged[32'(sel) * WORD_W +: WORD_W] = word;
        return merged;
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag and data arrays of the cache; combinational read, single write port, not reset.
module dcache_line_store
    import dcache_wb_controller_pkg::*;
(
    input  logic               clk_i,
    input  logic [INDEX_W-1:0] index,
    input  logic               we,
    input  logic [ENTRY_W-1:0] tag_wdata,
    input  logic [LINE_W-1:0]  data_wdata,
    output logic [ENTRY_W-1:0] tag_rdata,
    output logic [LINE_W-1:0]  data_rdata
);

    logic [ENTRY_W-1:0] tag_mem  [LINES];
    logic [LINE_W-1:0]  data_mem [LINES];

    always_ff @(posedge clk_i) begin
        if (we) begin
            tag_mem[index]  <= tag_wdata;
            data_mem[index] <= data_wdata;
        end
    end

    assign tag_rdata  = tag_mem[index];
    assign data_rdata = data_mem[index];

endmodule

// File: rtl/dcache_wb_controller.sv
// Direct-mapped write-back/write-allocate cache controller between MEM stage and Data_Memory.
module dcache_wb_controller
    import dcache_wb_controller_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [WORD_W-1:0] p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    state_t state_q, state_d;
    logic   gap_q, gap_d;
    logic   mem_en_q, mem_en_d;
    logic   mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_data_q, mem_data_d;

    logic [INDEX_W-1:0]    index;
    logic [TAG_W-1:0]      req_tag;
    logic [WORD_SEL_W-1:0] word_sel;
    logic                  req, is_write, hit;
    logic [ENTRY_W-1:0]    tag_rdata;
    logic [LINE_W-1:0]     data_rdata;
    tag_entry_t            entry, entry_wdata;
    logic [LINE_W-1:0]     data_wdata;
    logic                  store_we;
    logic                  unused_addr_bits;

    // Address is decoded live; upstream holds it stable while stalled.
    assign index            = p1_addr_i[OFFSET_W +: INDEX_W];
    assign req_tag          = p1_addr_i[OFFSET_W + INDEX_W +: TAG_W];
    assign word_sel         = p1_addr_i[2 +: WORD_SEL_W];
    assign unused_addr_bits = ^p1_addr_i[1:0];
    assign req              = p1_MemRead_i | p1_MemWrite_i;
    assign is_write         = p1_MemWrite_i;
    assign entry            = tag_entry_t'(tag_rdata);
    assign hit              = entry.valid && (entry.tag == req_tag);

    dcache_line_store u_store (
        .clk_i      (clk_i),
        .index      (index),
        .we         (store_we && rst_i),
        .tag_wdata  (ENTRY_W'(entry_wdata)),
        .data_wdata (data_wdata),
        .tag_rdata  (tag_rdata),
        .data_rdata (data_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            gap_q      <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            mem_en_q   <= mem_en_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Next state, registered memory-side values and array write control.
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        mem_en_d    = mem_en_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        store_we    = 1'b0;
        entry_wdata = entry;
        data_wdata  = data_rdata;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (is_write) begin
                            store_we          = 1'b1;
                            entry_wdata.dirty = 1'b1;
                            data_wdata        = merge_word(data_rdata, word_sel, p1_data_i);
                        end
                    end else if (entry.valid && entry.dirty) begin
                        state_d    = WRITEBACK;
                        mem_en_d   = 1'b1;
                        mem_wr_d   = 1'b1;
                        mem_addr_d = {entry.tag, index, OFFSET_W'(0)};
                        mem_data_d = data_rdata;
                    end else begin
                        state_d  = REFILL;
                        gap_d    = 1'b1;
                        mem_en_d = 1'b0;
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d  = REFILL;
                    gap_d    = 1'b1;
                    mem_en_d = 1'b0;
                    mem_wr_d = 1'b0;
                end
            end
            REFILL: begin
                // The first REFILL cycle keeps the memory request low.
                if (gap_q) begin
                    gap_d      = 1'b0;
                    mem_en_d   = 1'b1;
                    mem_wr_d   = 1'b0;
                    mem_addr_d = {req_tag, index, OFFSET_W'(0)};
                end else if (mem_ack_i) begin
                    store_we    = 1'b1;
                    entry_wdata = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
                    data_wdata  = mem_data_i;
                    mem_en_d    = 1'b0;
                    state_d     = REFILL_DONE;
                end
            end
            REFILL_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // CPU-side responses are combinational for zero-latency hits.
    always_comb begin
        p1_stall_o = (req && !hit && (state_q == IDLE)) || (state_q != IDLE);
        p1_data_o  = '0;
        if ((state_q == IDLE) && req && hit) begin
            p1_data_o = data_rdata[32'(word_sel) * WORD_W +: WORD_W];
        end
    end

    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_wr_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

endmodule
